ah_wrr_arbiter: RTL

- Parametrised weighted round-robin arbiter for N requesters, each with a configurable per-round credit weight.
- Next generation of the fixed 16-way weighted RR arbiter: N and weight width are parameters, a granted agent holds the grant for back-to-back bursts, and credits refresh from cfg only when no requester still holds credit.
- Sits in front of a shared resource (bus or port); outputs a registered one-hot grant plus an encoded index.

---
 rtl/ah_wrr_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ah_wrr_arbiter.sv
// ah_wrr_arbiter: weighted round-robin arbiter for N requesters.
// Each agent owns a per-round credit counter. A granted agent keeps the grant
// while it requests and has credit. Credits reload from cfg_weight only when no
// requester still holds credit. Outputs are registered.
// Optional build macro AH_WRR_LOCK_EN adds a 'lock' input. While asserted, lock
// pins the current grant without consuming credit.
module ah_wrr_arbiter #(
    parameter int N  = 16,
    parameter int WW = 6,
    parameter int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*WW-1:0]   cfg_weight,
`ifdef AH_WRR_LOCK_EN
    input  logic              lock,
`endif
    output logic [N-1:0]      gnt,
    output logic              gnt_valid,
    output logic [IW-1:0]     gnt_id,
    output logic              refresh
);

    logic [WW-1:0] credit   [N];
    logic [WW-1:0] credit_n [N];
    logic [WW-1:0] credit_d [N];
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] start;
    logic [IW-1:0] gnt_id_d;
    logic [IW-1:0] id_cr;
    logic [IW-1:0] id_cfg;
    logic [N-1:0]  gnt_d;
    logic [N-1:0]  elig_cr;
    logic [N-1:0]  elig_cfg;
    logic          gnt_valid_d;
    logic          refresh_d;
    logic          lock_hold;
    logic          found_cr;
    logic          found_cfg;

    // Circular first-set search starting at 'from'; returns {found, index}.
    function automatic logic [IW:0] find_first(input logic [N-1:0] v,
                                               input logic [IW-1:0] from);
        logic [IW-1:0] idx;
        logic [IW-1:0] hit;
        logic          found;
        idx   = from;
        hit   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && v[idx]) begin
                found = 1'b1;
                hit   = idx;
            end
            idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
        return {found, hit};
    endfunction

`ifdef AH_WRR_LOCK_EN
    assign lock_hold = gnt_valid & lock & req[gnt_id];
`else
    assign lock_hold = 1'b0;
`endif

    // Owner's credit after this cycle's use, plus the two eligibility masks.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            credit_n[i] = credit[i];
            if (gnt_valid && (gnt_id == IW'(i)) && req[i] && (credit[i] != '0)) begin
                credit_n[i] = credit[i] - WW'(1);
            end
            elig_cr[i]  = req[i] && (credit_n[i] != '0);
            elig_cfg[i] = req[i] && (cfg_weight[i*WW +: WW] != '0);
        end
    end

    // Search origin: one past the owner when moving on, else the stored pointer.
    always_comb begin
        start = ptr;
        if (gnt_valid) begin
            start = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
        end
        {found_cr, id_cr}   = find_first(elig_cr, start);
        {found_cfg, id_cfg} = find_first(elig_cfg, start);
    end

    // Next-grant decision: lock, hold, move to a credited agent, reload, or idle.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            credit_d[i] = credit_n[i];
        end
        ptr_d       = ptr;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        refresh_d   = 1'b0;
        if (lock_hold) begin
            // Locked owner keeps the grant and its credit is left untouched.
            for (int unsigned i = 0; i < N; i++) begin
                credit_d[i] = credit[i];
            end
            gnt_valid_d = 1'b1;
            gnt_id_d    = gnt_id;
        end else if (gnt_valid && elig_cr[gnt_id]) begin
            gnt_valid_d = 1'b1;
            gnt_id_d    = gnt_id;
        end else begin
            ptr_d = start;
            if (found_cr) begin
                gnt_valid_d = 1'b1;
                gnt_id_d    = id_cr;
            end else if (found_cfg) begin
                // Reload overwrites every counter, including the owner's decrement.
                for (int unsigned i = 0; i < N; i++) begin
                    credit_d[i] = cfg_weight[i*WW +: WW];
                end
                gnt_valid_d = 1'b1;
                gnt_id_d    = id_cfg;
                refresh_d   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            gnt_d[i] = gnt_valid_d && (gnt_id_d == IW'(i));
        end
    end

    // Register grant outputs, credits and search pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            refresh   <= 1'b0;
            ptr       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                credit[i] <= '0;
            end
        end else begin
            gnt       <= gnt_d;
            gnt_valid <= gnt_valid_d;
            gnt_id    <= gnt_id_d;
            refresh   <= refresh_d;
            ptr       <= ptr_d;
            for (int unsigned i = 0; i < N; i++) begin
                credit[i] <= credit_d[i];
            end
        end
    end

endmodule
